// File: rtl/wb_interconnect_if.sv
// Bus bundles for the 1-to-N Wishbone interconnect: one controller-side bundle
// and one broadcast peripheral-side bundle. Modport names are from the interconnect's view.
interface wb_ctrl_if #(
  parameter int AddrW = 8,
  parameter int DataW = 8
);
  logic             wb_we_i;
  logic [AddrW-1:0] wb_adr_i;
  logic [DataW-1:0] wb_dat_i;
  logic             wb_stb_i;
  logic [DataW-1:0] wb_dat_o;
  logic             wb_ack_o;
  logic             wb_err_o;

  modport master (
    output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

interface wb_peri_if #(
  parameter int PeriAddrW = 4,
  parameter int DataW     = 8,
  parameter int NPeri     = 4
);
  logic                   peri_we_o;
  logic [PeriAddrW-1:0]   peri_adr_o;
  logic [DataW-1:0]       peri_dat_o;
  logic [NPeri-1:0]       peri_stb_o;
  logic [NPeri*DataW-1:0] peri_dat_i;
  logic [NPeri-1:0]       peri_ack_i;

  modport master (
    output peri_we_o, peri_adr_o, peri_dat_o, peri_stb_o,
    input  peri_dat_i, peri_ack_i
  );

  modport slave (
    input  peri_we_o, peri_adr_o, peri_dat_o, peri_stb_o,
    output peri_dat_i, peri_ack_i
  );
endinterface

// File: rtl/wb_interconnect.sv
// Registered 1-to-N Wishbone interconnect: upper address bits pick a peripheral,
// with unmapped-address errors, a no-ack timeout and a saturating error counter.
module wb_interconnect #(
  parameter int              AddrW         = 8,
  parameter int              DataW         = 8,
  parameter int              PeriAddrW     = 4,
  parameter int              NPeri         = 4,
  parameter int              TimeoutCycles = 16,
  parameter logic [DataW-1:0] ErrData      = '1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_ctrl_if.slave   ctrl,
  wb_peri_if.master  peri,
  output logic [7:0] err_cnt_o
);

  localparam int                SelW    = AddrW - PeriAddrW;
  localparam int                CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [SelW:0]     NPeriL  = (SelW + 1)'(NPeri);
  localparam logic [CntW-1:0]   TmoLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [PeriAddrW-1:0] adr_q, adr_d;
  logic [DataW-1:0]     wdat_q, wdat_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic                 err_q, err_d;
  logic [DataW-1:0]     rdat_q, rdat_d;
  logic [CntW-1:0]      tmo_q, tmo_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic                 ack_sel;
  logic [DataW-1:0]     dat_sel;
  logic [NPeri-1:0]     stb_vec;
  logic [SelW-1:0]      sel_in;

  assign sel_in = ctrl.wb_adr_i[AddrW-1:PeriAddrW];

  // Only the selected peripheral's ack/data are visible; all other acks are ignored.
  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    stb_vec = '0;
    for (int k = 0; k < NPeri; k++) begin
      if (sel_q == SelW'(k)) begin
        ack_sel    = peri.peri_ack_i[k];
        dat_sel    = peri.peri_dat_i[k*DataW +: DataW];
        stb_vec[k] = (state_q == BUSY);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path leaves a latch.
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    err_d     = err_q;
    rdat_d    = rdat_q;
    tmo_d     = tmo_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl.wb_stb_i) begin
          we_d   = ctrl.wb_we_i;
          adr_d  = ctrl.wb_adr_i[PeriAddrW-1:0];
          wdat_d = ctrl.wb_dat_i;
          sel_d  = sel_in;
          tmo_d  = '0;
          if ({1'b0, sel_in} < NPeriL) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdat_d  = ErrData;
          end
        end
      end
      BUSY: begin
        // An ack arriving in the last allowed cycle still beats the timeout.
        if (ack_sel) begin
          rdat_d  = dat_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TmoLast) begin
          rdat_d  = ErrData;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      tmo_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ctrl.wb_dat_o   = rdat_q;
  assign ctrl.wb_ack_o   = (state_q == RESP);
  assign ctrl.wb_err_o   = (state_q == RESP) && err_q;
  assign peri.peri_we_o  = we_q;
  assign peri.peri_adr_o = adr_q;
  assign peri.peri_dat_o = wdat_q;
  assign peri.peri_stb_o = stb_vec;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboard bench for wb_interconnect: stimulus queues expected responses,
// a negedge monitor pops and compares data, error flag and response cycle.
module tb_wb_interconnect;

  typedef struct {
    logic [7:0] dat;
    logic       err;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         at_resp = 1'b0;
  exp_t       sb[$];
  int         ack_at[4];
  int         pcnt[4];
  logic [3:0] stray;

  wb_ctrl_if #(.AddrW(8), .DataW(8)) ctrl ();
  wb_peri_if #(.PeriAddrW(4), .DataW(8), .NPeri(4)) peri ();

  wb_interconnect #(
    .AddrW(8), .DataW(8), .PeriAddrW(4), .NPeri(4), .TimeoutCycles(16), .ErrData(8'hFF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ctrl     (ctrl),
    .peri     (peri),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral model: peripheral k acks in its ack_at[k]-th strobe cycle; stray bits ack constantly.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (peri.peri_stb_o[k]) pcnt[k] = pcnt[k] + 1;
      else                    pcnt[k] = 0;
      peri.peri_ack_i[k] = (peri.peri_stb_o[k] && ack_at[k] != 0 && pcnt[k] == ack_at[k]) || stray[k];
    end
  end

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ctrl.wb_ack_o) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("resp_dat", 32'(ctrl.wb_dat_o), 32'(e.dat));
        check("resp_err", 32'(ctrl.wb_err_o), 32'(e.err));
        check("resp_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one request; returns at the negedge of its response cycle with stb still high.
  task automatic issue(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                       input logic [7:0] exp_dat, input logic exp_err, input int d,
                       input logic [3:0] exp_stb, output int stb_cycles);
    int  e;
    bit  done;
    e = cyc + (at_resp ? 2 : 1);
    ctrl.wb_we_i  = we;
    ctrl.wb_adr_i = adr;
    ctrl.wb_dat_i = dat;
    ctrl.wb_stb_i = 1'b1;
    sb.push_back('{dat: exp_dat, err: exp_err, cyc: e + d});
    stb_cycles = 0;
    for (int i = 0; i < 4 && cyc != e; i++) @(negedge clk);
    check("first_cycle", 32'(cyc), 32'(e));
    check("peri_stb_c1", 32'(peri.peri_stb_o), 32'(exp_stb));
    if (exp_stb != 4'b0) begin
      check("peri_adr", 32'(peri.peri_adr_o), 32'(adr[3:0]));
      check("peri_we", 32'(peri.peri_we_o), 32'(we));
      check("peri_dat", 32'(peri.peri_dat_o), 32'(dat));
    end
    ctrl.wb_adr_i = 8'($urandom);
    ctrl.wb_dat_i = 8'($urandom);
    ctrl.wb_we_i  = ~we;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (peri.peri_stb_o != 4'b0) stb_cycles++;
      if (ctrl.wb_ack_o) done = 1'b1;
      else               @(negedge clk);
    end
    check("ack_seen", 32'(ctrl.wb_ack_o), 32'd1);
    check("peri_stb_resp", 32'(peri.peri_stb_o), 32'd0);
    if (exp_stb != 4'b0) check("peri_adr_hold", 32'(peri.peri_adr_o), 32'(adr[3:0]));
    at_resp = 1'b1;
  endtask

  task automatic idle(input int n);
    ctrl.wb_stb_i = 1'b0;
    repeat (n) @(negedge clk);
    at_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ctrl.wb_we_i = 1'b0; ctrl.wb_adr_i = '0; ctrl.wb_dat_i = '0; ctrl.wb_stb_i = 1'b0;
    peri.peri_dat_i = 32'h3C5C_2211;
    peri.peri_ack_i = '0;
    ack_at = '{0, 0, 0, 0};
    pcnt   = '{0, 0, 0, 0};
    stray  = 4'b0;
    #1;
    check("rst_ack", 32'(ctrl.wb_ack_o), 32'd0);
    check("rst_err", 32'(ctrl.wb_err_o), 32'd0);
    check("rst_stb", 32'(peri.peri_stb_o), 32'd0);
    check("rst_dat", 32'(ctrl.wb_dat_o), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Write to peri1, combinational ack; read data of peri1 captured anyway.
    ack_at[1] = 1;
    issue(1'b1, 8'h13, 8'hA5, 8'h22, 1'b0, 1, 4'b0010, n);
    idle(1);

    // Read from peri2, ack after three strobe cycles.
    ack_at[2] = 3;
    issue(1'b0, 8'h25, 8'h00, 8'h5C, 1'b0, 3, 4'b0100, n);
    check("stb_cycles_read", 32'(n), 32'd3);
    idle(1);

    // Unmapped select 7.
    issue(1'b0, 8'h70, 8'h00, 8'hFF, 1'b1, 0, 4'b0000, n);
    idle(1);
    check("err_cnt_unmapped", 32'(err_cnt), 32'd1);

    // peri0 never acks while peri1 acks constantly (must be ignored) -> timeout.
    ack_at[0] = 0;
    stray     = 4'b0010;
    issue(1'b0, 8'h07, 8'h00, 8'hFF, 1'b1, 16, 4'b0001, n);
    check("stb_cycles_tmo", 32'(n), 32'd16);
    idle(1);
    check("err_cnt_tmo", 32'(err_cnt), 32'd2);

    // Ack in the 16th strobe cycle wins over the timeout.
    ack_at[0] = 16;
    issue(1'b0, 8'h07, 8'h00, 8'h11, 1'b0, 16, 4'b0001, n);
    check("stb_cycles_ack16", 32'(n), 32'd16);
    idle(1);
    stray = 4'b0;
    check("err_cnt_ack16", 32'(err_cnt), 32'd2);

    // Reset in the middle of a BUSY transfer.
    ack_at[0] = 0;
    ctrl.wb_we_i = 1'b0; ctrl.wb_adr_i = 8'h05; ctrl.wb_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(peri.peri_stb_o), 32'b0001);
    #2 rst = 1'b1;
    #1;
    check("midrst_stb", 32'(peri.peri_stb_o), 32'd0);
    check("midrst_ack", 32'(ctrl.wb_ack_o), 32'd0);
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    ctrl.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    ack_at[3] = 2;
    issue(1'b0, 8'h3A, 8'h00, 8'h3C, 1'b0, 2, 4'b1000, n);
    idle(1);

    // Back-to-back with stb held high, then 300 unmapped accesses to saturate the counter.
    ack_at[0] = 1; ack_at[1] = 1; ack_at[2] = 1;
    issue(1'b0, 8'h01, 8'h00, 8'h11, 1'b0, 1, 4'b0001, n);
    issue(1'b1, 8'h12, 8'h6E, 8'h22, 1'b0, 1, 4'b0010, n);
    issue(1'b0, 8'h23, 8'h00, 8'h5C, 1'b0, 1, 4'b0100, n);
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, {4'(4 + (i % 12)), 4'(i)}, 8'h00, 8'hFF, 1'b1, 0, 4'b0000, n);
    end
    idle(2);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
